// File: rtl/vga_pkg.sv
// Shared 1280x1024@60 timing constants, widths and the control bundle
// carried alongside each pixel request through the latency pipeline.
package vga_pkg;

   localparam int COORD_W   = 11;
   localparam int RGB_W     = 24;
   localparam int SECONDS_W = 7;

   localparam logic [COORD_W-1:0] H_VISIBLE = 11'd1280;
   localparam logic [COORD_W-1:0] H_FRONT   = 11'd48;
   localparam logic [COORD_W-1:0] H_SYNC    = 11'd112;
   localparam logic [COORD_W-1:0] H_BACK    = 11'd248;
   localparam logic [COORD_W-1:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam logic [COORD_W-1:0] V_VISIBLE = 11'd1024;
   localparam logic [COORD_W-1:0] V_FRONT   = 11'd1;
   localparam logic [COORD_W-1:0] V_SYNC    = 11'd3;
   localparam logic [COORD_W-1:0] V_BACK    = 11'd38;
   localparam logic [COORD_W-1:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam logic [COORD_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 11'd1;
   localparam logic [COORD_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam logic [COORD_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 11'd1;

   localparam logic [SECONDS_W-1:0] SECONDS_LAST = 7'd99;

   typedef struct packed {
      logic valid;
      logic hsync;
      logic vsync;
   } ctrl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear; exposes the last stage
// and the one before it so a registered consumer can line up with the last.
module vga_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [WIDTH-1:0] o_prev
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[DEPTH-2:0], i_data};
      end
   end

   assign o_data = r_stage[DEPTH-1];
   assign o_prev = r_stage[DEPTH-2];

endmodule

// File: rtl/vga_timing_gen.sv
// 1280x1024@60 timing generator: raster counters issue pixel requests, and the
// sync/valid controls are delayed to meet pixel data returning LAT cycles later.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int LAT = 2,
   parameter int FPS = 60
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   output logic                 o_req_valid,
   output logic [COORD_W-1:0]   o_req_x,
   output logic [COORD_W-1:0]   o_req_y,
   input  logic [RGB_W-1:0]     i_rgb,
   output logic                 o_H_sync,
   output logic                 o_V_sync,
   output logic [RGB_W-1:0]     o_RGB,
   output logic                 o_frame_start,
   output logic [31:0]          o_frame_counter,
   output logic [SECONDS_W-1:0] o_seconds
);

   localparam int               FIS_W    = (FPS > 1) ? $clog2(FPS) : 1;
   localparam logic [FIS_W-1:0] FIS_LAST = FIS_W'(FPS - 1);

   logic [COORD_W-1:0]   r_h;
   logic [COORD_W-1:0]   r_v;
   logic [RGB_W-1:0]     r_rgb;
   logic [31:0]          r_frameCount;
   logic [FIS_W-1:0]     r_fis;
   logic [SECONDS_W-1:0] r_seconds;

   logic  w_hEnd;
   logic  w_vEnd;
   logic  w_frameEvent;
   ctrl_t w_reqCtrl;
   ctrl_t w_outCtrl;
   ctrl_t w_preCtrl;

   assign w_hEnd       = (r_h == H_TOTAL - 11'd1);
   assign w_vEnd       = (r_v == V_TOTAL - 11'd1);
   assign w_frameEvent = w_hEnd && w_vEnd;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_hEnd) begin
         r_h <= '0;
         r_v <= w_vEnd ? '0 : r_v + 11'd1;
      end else begin
         r_h <= r_h + 11'd1;
      end
   end

   assign o_req_x         = r_h;
   assign o_req_y         = r_v;
   assign o_req_valid     = (r_h < H_VISIBLE) && (r_v < V_VISIBLE);
   assign o_frame_start   = (r_h == '0) && (r_v == '0) && !i_rst;

   assign w_reqCtrl.valid = o_req_valid;
   assign w_reqCtrl.hsync = (r_h >= H_SYNC_START) && (r_h <= H_SYNC_END);
   assign w_reqCtrl.vsync = (r_v >= V_SYNC_START) && (r_v <= V_SYNC_END);

   vga_delay_line #(
      .WIDTH ($bits(ctrl_t)),
      .DEPTH (LAT + 1)
   ) u_align (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (w_reqCtrl),
      .o_data (w_outCtrl),
      .o_prev (w_preCtrl)
   );

   assign o_H_sync = w_outCtrl.hsync;
   assign o_V_sync = w_outCtrl.vsync;

   // The pixel is captured one stage early so the register lands with sync.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= w_preCtrl.valid ? i_rgb : '0;
      end
   end

   assign o_RGB = r_rgb;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frameCount <= '0;
         r_fis        <= '0;
         r_seconds    <= '0;
      end else if (w_frameEvent) begin
         r_frameCount <= r_frameCount + 32'd1;
         if (r_fis == FIS_LAST) begin
            r_fis     <= '0;
            r_seconds <= (r_seconds == SECONDS_LAST) ? '0 : r_seconds + 7'd1;
         end else begin
            r_fis <= r_fis + FIS_W'(1);
         end
      end
   end

   assign o_frame_counter = r_frameCount;
   assign o_seconds       = r_seconds;

endmodule
